main_mem_responder: RTL

- Memory-side responder for the data cache controller's block refill/write-back port.
- Accepts a single-cycle-sampled block read (mem_rden) or block write (mem_wren) and models main-memory latency. Answers with a one-cycle mem_ready pulse, with read data valid in that same cycle.
- Sits between the cache datapath and the system memory model; it is the slave end of the cache's WRITE_BACK/ALLOCATE handshake.

---
 rtl/mem_resp_pkg.sv | 26 ++
 rtl/mem_block_array.sv | 29 ++
 rtl/main_mem_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and geometry helpers for the main-memory responder.
// Imported by the responder top and its block array.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  // Byte-offset bits inside one block.
  function automatic int off_bits(input int block_width);
    return $clog2(block_width / 8);
  endfunction

  // Block-index bits for the stored array.
  function automatic int idx_bits(input int mem_blocks);
    return $clog2(mem_blocks);
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// Block storage with one synchronous write port and one registered read port.
// Only the read register is reset; the stored blocks survive reset.
module mem_block_array #(
  parameter int BLOCK_WIDTH = 128,
  parameter int MEM_BLOCKS  = 1024,
  parameter int IW          = $clog2(MEM_BLOCKS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic                   re,
  input  logic [IW-1:0]          idx,
  input  logic [BLOCK_WIDTH-1:0] wdata,
  output logic [BLOCK_WIDTH-1:0] rdata
);

  logic [BLOCK_WIDTH-1:0] mem [MEM_BLOCKS];

  // NOTE: storage is deliberately not reset so it maps onto RAM macros and keeps contents across reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/main_mem_responder.sv
// Slave end of the cache refill/write-back port: captures one block request,
// waits LATENCY cycles, then commits the write or returns the read with a one-cycle mem_ready.
module main_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WIDTH = 128,
  parameter int MEM_BLOCKS  = 1024,
  parameter int LATENCY     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_rden,
  input  logic                   mem_wren,
  input  logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [BLOCK_WIDTH-1:0] mem_wdata,
  output logic [BLOCK_WIDTH-1:0] mem_rdata,
  output logic                   mem_ready,
  output logic                   mem_busy
);

  localparam int OFF = off_bits(BLOCK_WIDTH);
  localparam int IW  = idx_bits(MEM_BLOCKS);
  localparam int CW  = $clog2(LATENCY + 1);

  state_e                 state;
  op_e                    op;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          lat_idx, addr_idx, arr_idx;
  logic [BLOCK_WIDTH-1:0] lat_wdata, arr_wdata;
  logic                   accept, wait_done, fast_accept, arr_we, arr_re;
  logic                   unused_addr;

  assign addr_idx    = mem_addr[OFF +: IW];
  assign unused_addr = ^mem_addr;
  assign accept      = (mem_rden | mem_wren) && (state != WAIT);
  assign wait_done   = (state == WAIT) && (cnt == '0);
  // With single-cycle latency the capture edge is also the commit edge, so the array sees the live inputs.
  assign fast_accept = (LATENCY == 1) && rst && accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = addr_idx;
    arr_wdata = mem_wdata;
    if (state == WAIT) begin
      arr_idx   = lat_idx;
      arr_wdata = lat_wdata;
      arr_we    = wait_done && (op == OP_WR);
      arr_re    = wait_done && (op == OP_RD);
    end else if (fast_accept) begin
      arr_we = mem_wren;
      arr_re = !mem_wren;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op        <= OP_RD;
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            op        <= mem_wren ? OP_WR : OP_RD;
            lat_idx   <= addr_idx;
            lat_wdata <= mem_wdata;
            if (LATENCY == 1) begin
              state     <= RESP;
              mem_ready <= 1'b1;
            end else begin
              state    <= WAIT;
              cnt      <= CW'(LATENCY - 2);
              mem_busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            mem_ready <= 1'b1;
          end else begin
            cnt      <= cnt - CW'(1);
            mem_busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_block_array #(
    .BLOCK_WIDTH(BLOCK_WIDTH),
    .MEM_BLOCKS (MEM_BLOCKS),
    .IW         (IW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (arr_we),
    .re   (arr_re),
    .idx  (arr_idx),
    .wdata(arr_wdata),
    .rdata(mem_rdata)
  );

endmodule
